s_div: RTL

S_DIV -- requirements
Module: s_div

---
 rtl/s_div_pkg.sv | 15 +
 rtl/s_div_step.sv | 28 ++
 rtl/s_div.sv | 110 +++++++++++
 3 files changed

// File: rtl/s_div_pkg.sv
// s_div shared types: FSM state encoding
// and iteration-counter width helper.
package s_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s_div_step.sv
// One restoring divide step (combinational).
// acc/num/den in; acc_next/num_next (quot bit in LSB) out.
module s_div_step
  import s_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] num_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted  = {acc, num[WIDTH-1]};
    diff     = shifted - {1'b0, den};
    fits     = ~diff[WIDTH];
    acc_next = fits ? diff[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
    num_next = {num[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/s_div.sv
// Signed restoring divider, fixed WIDTH+1 latency.
// _go/left/right in; quot/rem/done/busy out.
module s_div
  import s_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             _go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, num, den;
  logic [WIDTH-1:0] acc_next, num_next;
  logic             neg_q, neg_r, dz;
  logic             load, last;
  logic [WIDTH-1:0] abs_l, abs_r;
  logic [WIDTH-1:0] quot_n, rem_n;

  s_div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .num      (num),
    .den      (den),
    .acc_next (acc_next),
    .num_next (num_next)
  );

  // -2^(W-1) negates to itself, which read
  // unsigned is exactly its magnitude.
  always_comb begin
    abs_l = left[WIDTH-1] ? -left : left;
    abs_r = right[WIDTH-1] ? -right : right;
  end

  always_comb begin
    load = _go && (state != CALC);
    last = (cnt == CW'(WIDTH - 1));
  end

  // Zero divisor yields |left| as remainder,
  // so only the quotient needs forcing.
  always_comb begin
    quot_n = neg_q ? -num_next : num_next;
    if (dz) quot_n = '1;
    rem_n = neg_r ? -acc_next : acc_next;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: if (_go) state_n = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = _go ? CALC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      num   <= '0;
      den   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        cnt   <= '0;
        acc   <= '0;
        num   <= abs_l;
        den   <= abs_r;
        neg_q <= left[WIDTH-1] ^ right[WIDTH-1];
        neg_r <= left[WIDTH-1];
        dz    <= (right == '0);
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        acc <= acc_next;
        num <= num_next;
        if (last) begin
          quot <= quot_n;
          rem  <= rem_n;
        end
      end
    end
  end

endmodule
